digit_scan_controller: RTL and testbench

- Parametrised digit-select scanner for a multiplexed 7-segment/LED display.
- Generates the per-digit select (cathode/common) lines from its own prescaler.
- Replaces the fixed 4-digit, externally-counted selector.
- Adds digit count, polarity, a blanking interval between digits (anti-ghosting), a per-digit enable mask and run/stop control.
- Sits between the system clock domain and the display pins; segment data muxing downstream uses digit_idx.

---
 rtl/digit_scan_controller_pkg.sv | 21 ++
 rtl/digit_scan_controller_if.sv | 32 +++
 rtl/digit_scan_controller_scan_prescaler.sv | 36 +++
 rtl/digit_scan_controller.sv | 153 +++++++++++++++
 tb/tb_digit_scan_controller.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/digit_scan_controller_pkg.sv
// Shared definitions for the display scan blocks.
// Contents: scan FSM state encoding, default slot timing shared with the
// segment-data mux and other display blocks, and a width helper.
package digit_scan_controller_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BLANK  = 2'd1,
    ACTIVE = 2'd2
  } scan_state_t;

  localparam int DEFAULT_SLOT_CYCLES  = 100000;
  localparam int DEFAULT_BLANK_CYCLES = 1000;

  // $clog2 with a floor of one bit, so that tiny parameters still yield
  // a legal vector width.
  function automatic int width_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_scan_controller_if.sv
// Display scan bus: control inputs to the scanner and the registered
// digit-select outputs toward the display pins / segment-data mux.
//   en          scan run (1) / stop (0)
//   digit_mask  per-digit enable, sampled at slot start
//   select      digit select lines
//   digit_idx   index of the digit owning the current slot
//   blank       no digit driven this cycle
//   slot_start  first cycle of a slot
// master: the block controlling the scanner; slave: the scanner itself.
interface digit_scan_controller_if #(
  parameter int NUM_DIGITS = 4
);
  localparam int IDX_W = digit_scan_controller_pkg::width_min1(NUM_DIGITS);

  logic                  en;
  logic [NUM_DIGITS-1:0] digit_mask;
  logic [NUM_DIGITS-1:0] select;
  logic [IDX_W-1:0]      digit_idx;
  logic                  blank;
  logic                  slot_start;

  modport master (
    output en, digit_mask,
    input  select, digit_idx, blank, slot_start
  );

  modport slave (
    input  en, digit_mask,
    output select, digit_idx, blank, slot_start
  );

endinterface

// File: rtl/digit_scan_controller_scan_prescaler.sv
// Slot timer for the digit scanner: modulo-SLOT_CYCLES up-counter with
// synchronous clear.
//   clk, rst    clock, synchronous active-high reset
//   clr         synchronous clear (holds cnt at 0)
//   cnt         position inside the current slot
//   blank_done  last cycle of the blanking interval
//   wrap        last cycle of the slot
module scan_prescaler #(
  parameter int SLOT_CYCLES  = 8,
  parameter int BLANK_CYCLES = 2,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             blank_done,
  output logic             wrap
);

  assign wrap = (cnt == CNT_W'(SLOT_CYCLES - 1));

  // With no blanking interval there is no last blank cycle to flag.
  assign blank_done = (BLANK_CYCLES > 0) && (cnt == CNT_W'(BLANK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/digit_scan_controller.sv
// Digit-select scanner for a multiplexed 7-segment / LED display.
// Each digit owns a slot of SLOT_CYCLES cycles; the first BLANK_CYCLES of a
// slot drive no digit (anti-ghosting). Digits cleared in the mask still use
// their slot so refresh rate and duty stay constant.
//   clk, rst  clock, synchronous active-high reset
//   bus       digit_scan_controller_if.slave (en, digit_mask in;
//             select, digit_idx, blank, slot_start out, all registered)
//
// state  | meaning
// IDLE   | stopped, all selects off, waiting for en
// BLANK  | leading blank part of a slot, all selects off
// ACTIVE | remainder of the slot, digit idx driven if its mask bit is set
module digit_scan_controller
  import digit_scan_controller_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = DEFAULT_SLOT_CYCLES,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  digit_scan_controller_if.slave  bus
);

  localparam int IDX_W = width_min1(NUM_DIGITS);
  localparam int CNT_W = width_min1(SLOT_CYCLES);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{ACTIVE_LOW != 0}};
  localparam scan_state_t FIRST_STATE = (BLANK_CYCLES == 0) ? ACTIVE : BLANK;

  if (NUM_DIGITS < 2) begin : g_bad_digits
    $error("digit_scan_controller: NUM_DIGITS must be at least 2");
  end
  if (SLOT_CYCLES < 2) begin : g_bad_slot
    $error("digit_scan_controller: SLOT_CYCLES must be at least 2");
  end
  if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("digit_scan_controller: BLANK_CYCLES must be in [0, SLOT_CYCLES)");
  end

  scan_state_t           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  logic [NUM_DIGITS-1:0] onehot_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  blank_q, blank_d;
  logic                  ss_q, ss_d;

  logic [CNT_W-1:0]      cnt;
  logic                  blank_done;
  logic                  wrap;
  logic                  cnt_clr;

  // The timer only runs inside a slot; leaving the scan restarts it at 0
  // so a re-enable always begins with a full slot.
  assign cnt_clr = (state_q == IDLE) || !bus.en;

  scan_prescaler #(
    .SLOT_CYCLES  (SLOT_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES),
    .CNT_W        (CNT_W)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .cnt        (cnt),
    .blank_done (blank_done),
    .wrap       (wrap)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    ss_d    = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FIRST_STATE;
          idx_d   = '0;
          mask_d  = bus.digit_mask;
          ss_d    = 1'b1;
        end
        BLANK, ACTIVE: begin
          if (wrap) begin
            state_d = FIRST_STATE;
            // Explicit compare so non-power-of-two digit counts wrap cleanly.
            idx_d   = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
            mask_d  = bus.digit_mask;
            ss_d    = 1'b1;
          end else if (state_q == BLANK && blank_done) begin
            state_d = ACTIVE;
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from next-cycle values so they register on the same
  // edge as state/idx/mask.
  always_comb begin
    onehot_d = '0;
    if (state_d == ACTIVE) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx_d == IDX_W'(i) && mask_d[i]) begin
          onehot_d[i] = 1'b1;
        end
      end
    end
    sel_d   = onehot_d ^ SEL_OFF;
    blank_d = ~|onehot_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      sel_q   <= SEL_OFF;
      blank_q <= 1'b1;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      sel_q   <= sel_d;
      blank_q <= blank_d;
      ss_q    <= ss_d;
    end
  end

  assign bus.select     = sel_q;
  assign bus.digit_idx  = idx_q;
  assign bus.blank      = blank_q;
  assign bus.slot_start = ss_q;

  // Never more than one digit driven; the slot timer rests at 0 while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(sel_q ^ SEL_OFF));
      assert (state_q != IDLE || cnt == '0);
    end
  end

endmodule

// File: tb/tb_digit_scan_controller.sv
module tb_digit_scan_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   t_f2  = 0;

  always #5 clk = ~clk;

  // A: default scan, active-low. C: same timing, active-high (shares A's inputs).
  // B: 3 digits, 4-cycle slots, no blanking.
  digit_scan_controller_if #(.NUM_DIGITS(4)) bus_a ();
  digit_scan_controller_if #(.NUM_DIGITS(4)) bus_c ();
  digit_scan_controller_if #(.NUM_DIGITS(3)) bus_b ();

  digit_scan_controller #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(1))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  digit_scan_controller #(.NUM_DIGITS(4), .SLOT_CYCLES(8), .BLANK_CYCLES(2), .ACTIVE_LOW(0))
    dut_c (.clk(clk), .rst(rst), .bus(bus_c));
  digit_scan_controller #(.NUM_DIGITS(3), .SLOT_CYCLES(4), .BLANK_CYCLES(0), .ACTIVE_LOW(1))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ac(input logic en, input logic [3:0] mask);
    bus_a.en = en;  bus_a.digit_mask = mask;
    bus_c.en = en;  bus_c.digit_mask = mask;
  endtask

  // Entered at cycle 0 of a slot of digit d; checks ncyc cycles of it.
  // act is the active-low select for the digit, 4'b1111 for a masked slot.
  task automatic run_slot(input int d, input logic [3:0] act, input int ncyc,
                          input int chg_at, input logic [3:0] chg_mask);
    for (int k = 0; k < ncyc; k++) begin
      logic       on;
      logic [3:0] exp_a, exp_c;
      on    = (k >= 2) && (act != 4'b1111);
      exp_a = on ? act : 4'b1111;
      exp_c = on ? ~act : 4'b0000;
      chk($sformatf("a_ss d%0d k%0d", d, k), bus_a.slot_start, (k == 0));
      chk($sformatf("a_idx d%0d k%0d", d, k), bus_a.digit_idx, d);
      chk($sformatf("a_sel d%0d k%0d", d, k), bus_a.select, exp_a);
      chk($sformatf("a_blank d%0d k%0d", d, k), bus_a.blank, !on);
      chk($sformatf("c_sel d%0d k%0d", d, k), bus_c.select, exp_c);
      chk($sformatf("c_blank d%0d k%0d", d, k), bus_c.blank, !on);
      chk($sformatf("a_onehot d%0d k%0d", d, k), $onehot0(~bus_a.select), 1);
      chk($sformatf("c_onehot d%0d k%0d", d, k), $onehot0(bus_c.select), 1);
      if (k == chg_at) set_ac(1'b1, chg_mask);
      tick();
    end
  endtask

  task automatic chk_reset_ac(input string tag);
    chk({tag, "_a_sel"}, bus_a.select, 4'b1111);
    chk({tag, "_a_idx"}, bus_a.digit_idx, 0);
    chk({tag, "_a_blank"}, bus_a.blank, 1);
    chk({tag, "_a_ss"}, bus_a.slot_start, 0);
    chk({tag, "_c_sel"}, bus_c.select, 4'b0000);
    chk({tag, "_c_blank"}, bus_c.blank, 1);
  endtask

  initial begin
    logic [2:0] tbl_b [3];
    int         seq_b [4];
    tbl_b = '{3'b110, 3'b101, 3'b011};
    seq_b = '{0, 1, 2, 0};

    set_ac(1'b0, 4'b1111);
    bus_b.en = 1'b0;
    bus_b.digit_mask = 3'b111;

    // Reset for 3 cycles.
    rst = 1'b1;
    tick(); tick(); tick();
    chk_reset_ac("rst");
    chk("rst_b_sel", bus_b.select, 3'b111);
    chk("rst_b_blank", bus_b.blank, 1);

    // Default run: one full frame.
    rst = 1'b0;
    set_ac(1'b1, 4'b1111);
    tick();
    run_slot(0, 4'b1110, 8, -1, 4'b1111);
    run_slot(1, 4'b1101, 8, -1, 4'b1111);
    run_slot(2, 4'b1011, 8, -1, 4'b1111);
    run_slot(3, 4'b0111, 8, -1, 4'b1111);

    // Mask 0101 takes effect from digit 1; re-enabled mid-slot of digit 1.
    t_f2 = cyc;
    set_ac(1'b1, 4'b0101);
    run_slot(0, 4'b1110, 8, -1, 4'b0101);
    run_slot(1, 4'b1111, 8, 3, 4'b1111);
    run_slot(2, 4'b1011, 8, -1, 4'b1111);
    run_slot(3, 4'b0111, 8, -1, 4'b1111);
    chk("frame_len", cyc - t_f2, 32);
    run_slot(0, 4'b1110, 8, -1, 4'b1111);
    run_slot(1, 4'b1101, 8, -1, 4'b1111);

    // Enable drop during ACTIVE of digit 2.
    run_slot(2, 4'b1011, 4, -1, 4'b1111);
    set_ac(1'b0, 4'b1111);
    tick();
    chk_reset_ac("endrop");
    tick();
    chk_reset_ac("idle");
    set_ac(1'b1, 4'b1111);
    tick();
    run_slot(0, 4'b1110, 8, -1, 4'b1111);
    run_slot(1, 4'b1101, 8, -1, 4'b1111);
    run_slot(2, 4'b1011, 8, -1, 4'b1111);

    // Reset during BLANK of digit 3 with en still high.
    run_slot(3, 4'b0111, 1, -1, 4'b1111);
    rst = 1'b1;
    tick();
    chk_reset_ac("midrst");
    rst = 1'b0;
    tick();
    run_slot(0, 4'b1110, 8, -1, 4'b1111);
    run_slot(1, 4'b1101, 1, -1, 4'b1111);
    set_ac(1'b0, 4'b1111);

    // Non-power-of-two digit count, no blanking.
    bus_b.en = 1'b1;
    tick();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("b_ss s%0d k%0d", s, k), bus_b.slot_start, (k == 0));
        chk($sformatf("b_idx s%0d k%0d", s, k), bus_b.digit_idx, seq_b[s]);
        chk($sformatf("b_sel s%0d k%0d", s, k), bus_b.select, tbl_b[seq_b[s]]);
        chk($sformatf("b_blank s%0d k%0d", s, k), bus_b.blank, 0);
        tick();
      end
    end
    bus_b.en = 1'b0;
    tick();
    chk("b_stop_sel", bus_b.select, 3'b111);
    chk("b_stop_idx", bus_b.digit_idx, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
